// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder: operands and Start in, status and result out.
// The Sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         Sub;
`endif
  logic         Busy;
  logic         Done;
  logic [W-1:0] F;
  logic         Cout;
  logic         Ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output Start, A, B, Cin, Sub,
    input  Busy, Done, F, Cout, Ovf
  );
  modport slave (
    input  Start, A, B, Cin, Sub,
    output Busy, Done, F, Cout, Ovf
  );
`else
  modport master (
    output Start, A, B, Cin,
    input  Busy, Done, F, Cout, Ovf
  );
  modport slave (
    input  Start, A, B, Cin,
    output Busy, Done, F, Cout, Ovf
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit slice per clock, carry rippled through a register.
// Optional subtract mode (A + ~B + 1) enabled by defining SERIAL_ADDER_SUB_EN.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     a_op_reg;
  logic [W-1:0]     b_op_reg;
  logic [W-1:0]     sum_reg;
  logic [W-1:0]     f_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [W-1:0]     b_in;
  logic             cin_in;
  logic [3:0]       a_cur;
  logic [3:0]       b_cur;
  logic [4:0]       slice;
  logic             carry_into_msb;
  logic [W-1:0]     sum_next;

  // Subtraction is folded into the captured operand so the datapath stays add-only.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in   = bus.Sub ? ~bus.B : bus.B;
  assign cin_in = bus.Sub ? 1'b1   : bus.Cin;
`else
  assign b_in   = bus.B;
  assign cin_in = bus.Cin;
`endif

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_cur = a_op_reg[4*i +: 4];
        b_cur = b_op_reg[4*i +: 4];
      end
    end
  end

  assign slice = {1'b0, a_cur} + {1'b0, b_cur} + {4'b0000, carry_reg};
  // Sum bit 3 = a ^ b ^ carry-in, so the carry into bit 3 falls out of an XOR.
  assign carry_into_msb = a_cur[3] ^ b_cur[3] ^ slice[3];

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum_nibble
      assign sum_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? slice[3:0]
                                                           : sum_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_op_reg  <= '0;
      b_op_reg  <= '0;
      sum_reg   <= '0;
      f_reg     <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.Start) begin
            a_op_reg  <= bus.A;
            b_op_reg  <= b_in;
            carry_reg <= cin_in;
            sum_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice[4];
          idx_reg   <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            f_reg     <= sum_next;
            cout_reg  <= slice[4];
            ovf_reg   <= carry_into_msb ^ slice[4];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy = busy_reg;
  assign bus.Done = done_reg;
  assign bus.F    = f_reg;
  assign bus.Cout = cout_reg;
  assign bus.Ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against an arithmetic reference model.
// Exercises the subtract path too when SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sub_sel = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain (W+1)-bit arithmetic; signed overflow from operand/result sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // Presents one request and returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.Sub   = sub_sel;
`endif
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.Cin   = 1'($urandom);
  endtask

  // Counts edges until Done (bounded); busy_bad counts cycles where Busy disagreed with Done.
  task automatic wait_done(output int cycles, output int busy_bad);
    cycles   = -1;
    busy_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        if (bus.Busy !== 1'b0) busy_bad++;
        cycles = n;
        break;
      end
      if (bus.Busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.Sub   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.Busy, bus.Done, bus.F, bus.Cout, bus.Ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b F=%h cout=%b ovf=%b required all zero",
               bus.Busy, bus.Done, bus.F, bus.Cout, bus.Ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_start: got busy=%b done=%b required 0 0", bus.Busy, bus.Done);
    end
    $display("[TB] reset: busy=%b done=%b F=%h", bus.Busy, bus.Done, bus.F);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h0FFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb [5] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] te [5] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b00, 16'h1000},
                             {2'b10, 16'h8000}, {2'b11, 16'h0000}};
    int cycles, busy_bad;
    sub_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i], tc[i]);
      tests++;
      if (bus.Busy !== 1'b1) begin
        fails++;
        $display("FAIL accept_busy: got %b required 1", bus.Busy);
      end
      wait_done(cycles, busy_bad);
      $display("[TB] directed a=%h b=%h cin=%b -> F=%h cout=%b ovf=%b after %0d cycles",
               ta[i], tb[i], tc[i], bus.F, bus.Cout, bus.Ovf, cycles);
      tests++;
      if (cycles !== NIB) begin
        fails++;
        $display("FAIL directed_latency: got %0d required %0d", cycles, NIB);
      end
      tests++;
      if (busy_bad !== 0) begin
        fails++;
        $display("FAIL directed_busy: got %0d bad cycles required 0", busy_bad);
      end
      tests++;
      if ({bus.Ovf, bus.Cout, bus.F} !== te[i]) begin
        fails++;
        $display("FAIL directed_result: got ovf=%b cout=%b F=%h required ovf=%b cout=%b F=%h",
                 bus.Ovf, bus.Cout, bus.F, te[i][W+1], te[i][W], te[i][W-1:0]);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({bus.Done, bus.Busy, bus.F} !== {2'b00, te[i][W-1:0]}) begin
        fails++;
        $display("FAIL done_pulse: got done=%b busy=%b F=%h required 0 0 %h",
                 bus.Done, bus.Busy, bus.F, te[i][W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         cin;
    logic [W+1:0] exp;
    int cycles, busy_bad;
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub_sel = 1'($urandom);
`else
      sub_sel = 1'b0;
`endif
      exp = model(a, b, cin, sub_sel);
      launch(a, b, cin);
      wait_done(cycles, busy_bad);
      $display("[TB] random a=%h b=%h cin=%b sub=%b -> F=%h cout=%b ovf=%b exp F=%h cout=%b ovf=%b",
               a, b, cin, sub_sel, bus.F, bus.Cout, bus.Ovf, exp[W-1:0], exp[W], exp[W+1]);
      tests++;
      if (cycles !== NIB || busy_bad !== 0) begin
        fails++;
        $display("FAIL random_timing: got %0d cycles busy_bad=%0d required %0d and 0",
                 cycles, busy_bad, NIB);
      end
      tests++;
      if ({bus.Ovf, bus.Cout, bus.F} !== exp) begin
        fails++;
        $display("FAIL random_result: got ovf=%b cout=%b F=%h required ovf=%b cout=%b F=%h",
                 bus.Ovf, bus.Cout, bus.F, exp[W+1], exp[W], exp[W-1:0]);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    sub_sel = 1'b0;
  endtask

  task automatic test_start_in_run();
    logic [W+1:0] exp;
    int cycles, busy_bad;
    sub_sel = 1'b0;
    exp = model(16'h1357, 16'h2468, 1'b1, 1'b0);
    launch(16'h1357, 16'h2468, 1'b1);
    @(posedge clk);
    #1;
    launch(16'hAAAA, 16'hAAAA, 1'b0);
    wait_done(cycles, busy_bad);
    $display("[TB] start_in_run -> F=%h cout=%b ovf=%b, done %0d cycles after extra start",
             bus.F, bus.Cout, bus.Ovf, cycles);
    tests++;
    if (cycles !== NIB - 2) begin
      fails++;
      $display("FAIL run_start_latency: got %0d required %0d", cycles, NIB - 2);
    end
    tests++;
    if ({bus.Ovf, bus.Cout, bus.F} !== exp) begin
      fails++;
      $display("FAIL run_start_result: got ovf=%b cout=%b F=%h required ovf=%b cout=%b F=%h",
               bus.Ovf, bus.Cout, bus.F, exp[W+1], exp[W], exp[W-1:0]);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      fails++;
      $display("FAIL run_start_no_second: got busy=%b done=%b required 0 0", bus.Busy, bus.Done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp1, exp2;
    int cycles, busy_bad;
    sub_sel = 1'b0;
    exp1 = model(16'hC0DE, 16'h5A5A, 1'b0, 1'b0);
    exp2 = model(16'h0F0F, 16'hF0F1, 1'b1, 1'b0);
    launch(16'hC0DE, 16'h5A5A, 1'b0);
    wait_done(cycles, busy_bad);
    tests++;
    if ({bus.Ovf, bus.Cout, bus.F} !== exp1) begin
      fails++;
      $display("FAIL b2b_first: got ovf=%b cout=%b F=%h required ovf=%b cout=%b F=%h",
               bus.Ovf, bus.Cout, bus.F, exp1[W+1], exp1[W], exp1[W-1:0]);
    end
    // Already inside the DONE cycle: hold Start through its closing edge.
    bus.Start = 1'b1;
    bus.A     = 16'h0F0F;
    bus.B     = 16'hF0F1;
    bus.Cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    tests++;
    if ({bus.Busy, bus.Done} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b done=%b required 1 0", bus.Busy, bus.Done);
    end
    wait_done(cycles, busy_bad);
    $display("[TB] back_to_back second -> F=%h cout=%b ovf=%b, done %0d cycles after first Done",
             bus.F, bus.Cout, bus.Ovf, cycles + 1);
    tests++;
    if (cycles + 1 !== NIB + 1) begin
      fails++;
      $display("FAIL b2b_latency: got %0d required %0d", cycles + 1, NIB + 1);
    end
    tests++;
    if ({bus.Ovf, bus.Cout, bus.F} !== exp2) begin
      fails++;
      $display("FAIL b2b_second: got ovf=%b cout=%b F=%h required ovf=%b cout=%b F=%h",
               bus.Ovf, bus.Cout, bus.F, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
  endtask

  task automatic test_async_reset();
    int cycles, busy_bad, done_seen;
    logic [W+1:0] exp;
    sub_sel = 1'b0;
    launch(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.Busy, bus.Done, bus.F, bus.Cout, bus.Ovf} !== '0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b F=%h cout=%b ovf=%b required all zero",
               bus.Busy, bus.Done, bus.F, bus.Cout, bus.Ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) done_seen++;
    end
    tests++;
    if (done_seen !== 0) begin
      fails++;
      $display("FAIL async_reset_discard: got %0d active cycles required 0", done_seen);
    end
    exp = model(16'h7654, 16'h0321, 1'b1, 1'b0);
    launch(16'h7654, 16'h0321, 1'b1);
    wait_done(cycles, busy_bad);
    $display("[TB] after async reset -> F=%h cout=%b ovf=%b after %0d cycles",
             bus.F, bus.Cout, bus.Ovf, cycles);
    tests++;
    if (cycles !== NIB || {bus.Ovf, bus.Cout, bus.F} !== exp) begin
      fails++;
      $display("FAIL post_reset_add: got %0d cycles F=%h cout=%b ovf=%b required %0d cycles F=%h cout=%b ovf=%b",
               cycles, bus.F, bus.Cout, bus.Ovf, NIB, exp[W-1:0], exp[W], exp[W+1]);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] ta [2] = '{16'h0005, 16'h8000};
    logic [W-1:0] tb [2] = '{16'h0007, 16'h0001};
    logic [W+1:0] te [2] = '{{2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
    int cycles, busy_bad;
    sub_sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      launch(ta[i], tb[i], 1'b0);
      wait_done(cycles, busy_bad);
      $display("[TB] sub a=%h b=%h -> F=%h cout=%b ovf=%b", ta[i], tb[i], bus.F, bus.Cout, bus.Ovf);
      tests++;
      if ({bus.Ovf, bus.Cout, bus.F} !== te[i] || cycles !== NIB) begin
        fails++;
        $display("FAIL sub_result: got ovf=%b cout=%b F=%h in %0d cycles required ovf=%b cout=%b F=%h",
                 bus.Ovf, bus.Cout, bus.F, cycles, te[i][W+1], te[i][W], te[i][W-1:0]);
      end
    end
    sub_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_in_run();
    test_back_to_back();
    test_async_reset();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
